// File: rtl/multiplier_stg_recon.sv
// Sequential shift-and-add multiply-accumulate: product = word1 * word2 + addend.
// Rebuilds a dividend from a divider's (quotient, divisor, remainder) with the same Start/Ready handshake.
module multiplier_stg_recon #(
   parameter int L_mcnd  = 8,
   parameter int L_mplr  = 4,
   parameter int L_prod  = L_mcnd + L_mplr,
   parameter int L_state = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [L_mcnd-1:0] word1,
   input  logic [L_mplr-1:0] word2,
   input  logic [L_mplr-1:0] addend,
   input  logic              Start,
   output logic [L_prod-1:0] product,
   output logic              Ready,
   output logic              Done,
   output logic              Ovf
);

   typedef enum logic [L_state-1:0] {
      S_idle = L_state'(0),
      S_run  = L_state'(1),
      S_done = L_state'(2)
   } state_t;

   state_t            state_reg, state_next;
   logic [L_prod-1:0] acc_reg, acc_next;
   logic [L_prod-1:0] mcnd_reg, mcnd_next;
   logic [L_mplr-1:0] mplr_reg, mplr_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= S_idle;
         acc_reg   <= '0;
         mcnd_reg  <= '0;
         mplr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         mcnd_reg  <= mcnd_next;
         mplr_reg  <= mplr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      mcnd_next  = mcnd_reg;
      mplr_next  = mplr_reg;
      case (state_reg)
         S_idle: begin
            if (Start) begin
               acc_next   = L_prod'(addend);
               mcnd_next  = L_prod'(word1);
               mplr_next  = word2;
               // A zero operand leaves the addend as the result, so skip the run phase.
               state_next = (word1 == '0 || word2 == '0) ? S_done : S_run;
            end
         end
         S_run: begin
            if (mplr_reg[0])
               acc_next = acc_reg + mcnd_reg;
            mcnd_next  = mcnd_reg << 1;
            mplr_next  = mplr_reg >> 1;
            // Stop as soon as no set multiplier bits remain (leading zeros are skipped).
            state_next = ((mplr_reg >> 1) == '0) ? S_done : S_run;
         end
         S_done:  state_next = S_idle;
         default: state_next = S_idle;
      endcase
   end

   assign product = acc_reg;
   assign Ready   = (state_reg == S_idle) && !reset;
   assign Done    = (state_reg == S_done);
   assign Ovf     = |acc_reg[L_prod-1:L_mcnd];

endmodule
